// File: rtl/osc_ker_clk_req_ctrl.sv
// Oscillator kernel-clock request controller.
// Merges peripheral/software requests, starts the oscillator and grants acks.
module osc_ker_clk_req_ctrl #(
    parameter int REQ_NUM   = 8,
    parameter int TIMEOUT   = 255,
    parameter int OFF_DELAY = 4
) (
    input  logic               i_clk,
    input  logic               rst_n,
    input  logic [REQ_NUM-1:0] per_ker_clk_req,
    input  logic               sw_osc_on,
    input  logic               osc_rdy,
    input  logic               err_clr,
    output logic               osc_en,
    output logic [REQ_NUM-1:0] per_ker_clk_ack,
    output logic [1:0]         osc_state,
    output logic               timeout_err
);

    localparam int CW_TO = $clog2(TIMEOUT + 1);
    localparam int CW_OD = $clog2(OFF_DELAY + 1);
    localparam int CW_M  = (CW_TO > CW_OD) ? CW_TO : CW_OD;
    localparam int CW    = (CW_M > 1) ? CW_M : 1;

    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LD =
        CW'((OFF_DELAY > 0) ? OFF_DELAY - 1 : 0);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_WAIT = 2'd1,
        S_ON   = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          to_hit;
    logic          any_req;

    assign any_req = (|per_ker_clk_req) | sw_osc_on;

    // State, shared WAIT/HOLD counter and sticky error register
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state and counter decode; a fresh timeout beats err_clr
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_hit  = 1'b0;
        unique case (state_q)
            S_OFF: begin
                if (any_req) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (osc_rdy) begin
                    state_d = S_ON;
                end else if (!any_req) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                    to_hit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ON: begin
                if (!osc_rdy) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (!any_req) begin
                    if (OFF_DELAY == 0) begin
                        state_d = S_OFF;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_LD;
                    end
                end
            end
            S_HOLD: begin
                if (any_req) begin
                    if (osc_rdy) begin
                        state_d = S_ON;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == '0) begin
                    state_d = S_OFF;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
        err_d = to_hit | (err_q & ~err_clr);
    end

    // Enable comes from the state register only; acks pass through in ON
    always_comb begin
        osc_en          = (state_q != S_OFF);
        osc_state       = state_q;
        timeout_err     = err_q;
        per_ker_clk_ack = '0;
        if (state_q == S_ON && osc_rdy) begin
            per_ker_clk_ack = per_ker_clk_req;
        end
    end

endmodule

// File: tb/tb_osc_ker_clk_req_ctrl.sv
// Directed bench for osc_ker_clk_req_ctrl.
// Cycle n is observed 1-2 ns after the n-th rising edge.
module tb_osc_ker_clk_req_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       sw;
    logic       rdy;
    logic       clr;
    logic       en;
    logic [7:0] ack;
    logic [1:0] st;
    logic       err;

    int checks   = 0;
    int failures = 0;

    logic [11:0] exp;
    wire  [11:0] got = {st, en, err, ack};

    always #5 clk = ~clk;

    osc_ker_clk_req_ctrl #(
        .REQ_NUM  (8),
        .TIMEOUT  (8),
        .OFF_DELAY(4)
    ) dut (
        .i_clk          (clk),
        .rst_n          (rst_n),
        .per_ker_clk_req(req),
        .sw_osc_on      (sw),
        .osc_rdy        (rdy),
        .err_clr        (clr),
        .osc_en         (en),
        .per_ker_clk_ack(ack),
        .osc_state      (st),
        .timeout_err    (err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        sw    = 1'b0;
        rdy   = 1'b0;
        clr   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        sw    = 1'b1;
        rdy   = 1'b1;
        clr   = 1'b0;
        #2;
        exp = 12'h000;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_async got=%h exp=%h", got, exp);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_held got=%h exp=%h", got, exp);
        end
        req = '0;
        sw  = 1'b0;
        rdy = 1'b0;
        rst_n = 1'b1;
        cyc();
        #1;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_cold_start();
        do_reset();
        req = 8'h01;
        #1;
        exp = 12'h000;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL cold_c0 got=%h exp=%h", got, exp);
        end
        for (int c = 1; c <= 8; c++) begin
            cyc();
            if (c == 5) rdy = 1'b1;
            #1;
            if (c < 6) exp = {2'd1, 1'b1, 1'b0, 8'h00};
            else       exp = {2'd2, 1'b1, 1'b0, 8'h01};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL cold_c%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_hysteresis(input bit reraise);
        do_reset();
        req = 8'h01;
        rdy = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            cyc();
            if (c == 10) req = 8'h00;
            if (reraise && c == 13) req = 8'h08;
            #1;
            if (c == 1)
                exp = {2'd1, 1'b1, 1'b0, 8'h00};
            else if (c < 10)
                exp = {2'd2, 1'b1, 1'b0, 8'h01};
            else if (c == 10)
                exp = {2'd2, 1'b1, 1'b0, 8'h00};
            else if (reraise && c >= 14)
                exp = {2'd2, 1'b1, 1'b0, 8'h08};
            else if (c <= 14)
                exp = {2'd3, 1'b1, 1'b0, 8'h00};
            else
                exp = {2'd0, 1'b0, 1'b0, 8'h00};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL hyst_r%0d_c%0d got=%h exp=%h",
                         reraise, c, got, exp);
            end
        end
    endtask

    task automatic test_timeout();
        logic [1:0] es;
        do_reset();
        req = 8'h01;
        rdy = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            clr = (c == 17 || c == 19);
            #1;
            es  = (c == 9 || c == 18) ? 2'd0 : 2'd1;
            exp = {es, es != 2'd0, (c >= 9 && c < 20), 8'h00};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL timeout_c%0d got=%h exp=%h", c, got, exp);
            end
        end
        clr = 1'b0;
        req = 8'h00;
    endtask

    task automatic test_ready_loss();
        do_reset();
        req = 8'h02;
        rdy = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            if (c == 4) rdy = 1'b0;
            if (c == 6) rdy = 1'b1;
            #1;
            if (c == 1 || c == 5 || c == 6)
                exp = {2'd1, 1'b1, 1'b0, 8'h00};
            else if (c == 4)
                exp = {2'd2, 1'b1, 1'b0, 8'h00};
            else
                exp = {2'd2, 1'b1, 1'b0, 8'h02};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL rdyloss_c%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_sw_on();
        do_reset();
        sw  = 1'b1;
        rdy = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            if (c == 4) req = 8'h20;
            #1;
            if (c == 1)
                exp = {2'd1, 1'b1, 1'b0, 8'h00};
            else
                exp = {2'd2, 1'b1, 1'b0, (c >= 4) ? 8'h20 : 8'h00};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL swon_c%0d got=%h exp=%h", c, got, exp);
            end
        end
        sw  = 1'b0;
        req = 8'h00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h01;
        rdy = 1'b1;
        cyc();
        cyc();
        req = 8'h00;
        cyc();
        #1;
        exp = {2'd3, 1'b1, 1'b0, 8'h00};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL rstmid_hold_pre got=%h exp=%h", got, exp);
        end
        rst_n = 1'b0;
        req   = 8'hFF;
        #1;
        exp = 12'h000;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL rstmid_hold got=%h exp=%h", got, exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        #1;
        exp = {2'd1, 1'b1, 1'b0, 8'h00};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL rstmid_restart got=%h exp=%h", got, exp);
        end
        do_reset();
        req = 8'h01;
        rdy = 1'b0;
        repeat (10) cyc();
        #1;
        exp = {2'd1, 1'b1, 1'b1, 8'h00};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL rstmid_wait_pre got=%h exp=%h", got, exp);
        end
        rst_n = 1'b0;
        #1;
        exp = 12'h000;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL rstmid_wait got=%h exp=%h", got, exp);
        end
        req = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        #1;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL rstmid_idle got=%h exp=%h", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_hysteresis(1'b0);
        test_hysteresis(1'b1);
        test_timeout();
        test_ready_loss();
        test_sw_on();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
